// File: rtl/crc8_pkg.sv
// ============================================================================
// crc8_pkg : shared constants, state encoding and byte-wise CRC-8 update
// Revision : 1.0
// ============================================================================
`default_nettype none

package crc8_pkg;

  localparam logic [7:0] CRC8_DEFAULT_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT         = 8'h00;

  typedef logic [0:0] state_t;
  localparam state_t ST_DATA   = 1'b0;
  localparam state_t ST_APPEND = 1'b1;

  // MSB-first, non-reflected CRC-8 update over one byte.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc8.sv
// ============================================================================
// crc8 : byte-serial CRC-8 engine, init 0, no reflection, no final xor
// Revision : 1.0
// ============================================================================
`default_nettype none

module crc8
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = CRC8_DEFAULT_POLY
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_d;
  logic [7:0] crc_q;

  always_comb begin
    crc_d = crc_q;
    if (rst_i) begin
      crc_d = CRC8_INIT;
    end else if (data_valid_i) begin
      crc_d = crc8_update(crc_q, data_i, POLYNOMIAL);
    end
  end

  always_ff @(posedge clk_i) begin
    crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/crc8_framer.sv
// ============================================================================
// crc8_framer : forwards a valid/ready/last byte stream and appends CRC-8
// Revision : 1.0
// ============================================================================
`default_nettype none

module crc8_framer
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = CRC8_DEFAULT_POLY,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           s_data_i,
  input  logic                 s_valid_i,
  input  logic                 s_last_i,
  output logic                 s_ready_o,
  output logic [7:0]           m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic [CNT_WIDTH-1:0] frame_cnt_o
);

  state_t               state_d, state_q;
  logic                 m_valid_d, m_valid_q;
  logic                 m_last_d, m_last_q;
  logic [7:0]           m_data_d, m_data_q;
  logic [CNT_WIDTH-1:0] frame_cnt_d, frame_cnt_q;
  logic                 slot_free;
  logic                 crc_rst;
  logic                 crc_valid;
  logic [7:0]           crc_value;

  crc8 #(
    .POLYNOMIAL (POLYNOMIAL)
  ) u_crc8 (
    .clk_i        (clk_i),
    .rst_i        (crc_rst),
    .data_valid_i (crc_valid),
    .data_i       (s_data_i),
    .crc_o        (crc_value)
  );

  always_comb begin
    slot_free   = ~m_valid_q | m_ready_i;
    state_d     = state_q;
    m_valid_d   = m_valid_q & ~m_ready_i;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    frame_cnt_d = frame_cnt_q;
    s_ready_o   = 1'b0;
    crc_valid   = 1'b0;
    crc_rst     = ~rst_ni;
    case (state_q)
      ST_DATA: begin
        s_ready_o = slot_free;
        if (s_valid_i && slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_i;
          m_last_d  = 1'b0;
          crc_valid = 1'b1;
          if (s_last_i) begin
            state_d = ST_APPEND;
          end
        end
      end
      ST_APPEND: begin
        // Engine is cleared in the same cycle its result is captured.
        if (slot_free) begin
          m_valid_d   = 1'b1;
          m_data_d    = crc_value;
          m_last_d    = 1'b1;
          crc_rst     = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          state_d     = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_DATA;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= 8'h00;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_data_o    = m_data_q;
  assign m_valid_o   = m_valid_q;
  assign m_last_o    = m_last_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

`default_nettype wire
